imem_stream_loader: RTL
=======================

Name: imem_stream_loader

Overview:
- Parametrised instruction memory for the MIPS core, replacing the fixed 64x32 loadable ROM.
- Combinational host fetch port, combinational debug examine port, and a streaming valid/ready loader.
- Loader writes a burst of words from a base address with auto-increment and wrap-around, and keeps a running checksum.
- While a load is in progress, the block stalls the host core and feeds it NOPs.

Parameters:
- DATA_W, 32, word width in bits
- ADDR_W, 6, word-address width; DEPTH = 2**ADDR_W words

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- rd_addr  input  ADDR_W  host fetch word address
- rd_data  output  DATA_W  host fetch data, combinational
- host_hold  output  1  stall request to core, high while loading
- dbg_addr  input  ADDR_W  external examine address
- dbg_data  output  DATA_W  external examine data, combinational
- ld_start  input  1  begin load burst, sampled in IDLE only
- ld_base  input  ADDR_W  first write address, captured at start
- ld_count  input  ADDR_W+1  number of words, 0..DEPTH, captured at start
- ld_valid  input  1  loader word valid
- ld_data  input  DATA_W  loader word
- ld_ready  output  1  block accepts a word this cycle
- ld_abort  input  1  terminate burst early
- ld_busy  output  1  burst in progress
- ld_done  output  1  one-cycle pulse at burst end, normal or aborted
- ld_aborted  output  1  set with ld_done if the burst was aborted; held until next start
- ld_csum  output  DATA_W  sum of accepted words mod 2**DATA_W; held until next start

Behaviour:
- Memory
  - DEPTH x DATA_W array, all zero at time zero.
  - Reset does not alter contents.
  - Words written on the rising edge only.
- Reads
  - dbg_data = mem[dbg_addr], combinational, valid in every state.
  - rd_data = mem[rd_addr] when host_hold=0, else 0 (NOP).
  - Read of the address being written in the same cycle returns the old word; the new word is visible the cycle after the edge.
- FSM states: IDLE, LOAD, DONE.
  - IDLE, ld_start=1, ld_count>0: capture waddr<=ld_base, remain<=ld_count, csum<=0, ld_aborted<=0; go to LOAD.
  - IDLE, ld_start=1, ld_count=0: csum<=0, ld_aborted<=0; go to DONE directly, no write.
  - LOAD: ld_ready=1, ld_busy=1, host_hold=1.
    - On ld_valid&&ld_ready: mem[waddr]<=ld_data; waddr<=waddr+1, wrapping DEPTH-1 -> 0; remain<=remain-1; csum<=csum+ld_data.
    - When the accepted word makes remain 0: go to DONE.
  - LOAD, ld_abort=1: go to DONE with ld_aborted<=1.
    - Abort has priority over a simultaneous handshake; that word is not written.
  - DONE: ld_done=1 for exactly one cycle; ld_busy=0, ld_ready=0, host_hold=0; go to IDLE.
  - ld_start in LOAD or DONE is ignored. ld_abort in IDLE or DONE is ignored.
- Throughput and latency
  - One word per cycle max.
  - Burst of N words with ld_valid held high: ld_busy for N cycles, ld_done N+1 cycles after the start edge.
  - ld_count=DEPTH writes every location exactly once.
  - Base+count past DEPTH wraps and overwrites low addresses.
- Async reset (rst_n=0), any time including mid-burst:
  - State -> IDLE; ld_ready, ld_busy, ld_done, host_hold, ld_aborted = 0; ld_csum=0; waddr and remain = 0.
  - Words already written are retained.
  - No ld_done pulse for a reset-killed burst.

Test Plan:
- Time-zero read, no load: dbg_addr=5, rd_addr=5 -> dbg_data=0, rd_data=0, host_hold=0.
- Load base=2, count=3, words 0x11,0x22,0x33 back-to-back:
  - ld_busy 3 cycles, ld_done on the 4th, ld_csum=0x66.
  - mem[2..4]=0x11,0x22,0x33, readable on rd_data afterward.
  - rd_data=0 while host_hold=1.
- Wrap: base=62, count=4, ADDR_W=6, words A,B,C,D -> mem[62]=A, mem[63]=B, mem[0]=C, mem[1]=D.
- Backpressure and abort: ld_valid toggled 1,0,1, then ld_abort together with a 3rd valid word:
  - Only 2 words written, ld_aborted=1, ld_done single pulse.
  - ld_csum = sum of the 2 written words.
- Edge starts: ld_count=0 -> ld_done next cycle, ld_csum=0, no writes. ld_start during LOAD -> ignored, base unchanged.
- Reset mid-burst after 2 of 5 words:
  - Outputs zero immediately without a clock edge.
  - First 2 words retained, no ld_done.
  - New burst afterwards runs normally.

Source files
------------

// File: rtl/imem_stream_loader.sv
// Instruction memory with combinational host/debug reads and a streaming burst loader.
// Latency: reads are combinational; a loaded word becomes readable the cycle after its accept edge.
// Backpressure: ld_ready is high only in LOAD; the host core is held and fed NOPs for the whole burst.
module imem_stream_loader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              host_hold,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  input  logic              ld_abort,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_aborted,
  output logic [DATA_W-1:0] ld_csum
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [CNT_W-1:0]    remain_q, remain_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic                aborted_q, aborted_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                hold_q, hold_d;
  logic                wr_en;

  // Storage has no reset so a reset never disturbs loaded code; it powers up cleared.
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

  // A word is written only on a real handshake in LOAD; a simultaneous abort wins and drops it.
  assign wr_en = (state_q == S_LOAD) && ld_valid && !ld_abort;

  // Next-state, burst bookkeeping and registered status outputs.
  always_comb begin
    state_d   = state_q;
    waddr_d   = waddr_q;
    remain_d  = remain_q;
    csum_d    = csum_q;
    aborted_d = aborted_q;
    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          csum_d    = '0;
          aborted_d = 1'b0;
          if (ld_count != '0) begin
            waddr_d  = ld_base;
            remain_d = ld_count;
            state_d  = S_LOAD;
          end else begin
            // Empty burst: report completion without touching memory.
            state_d = S_DONE;
          end
        end
      end
      S_LOAD: begin
        if (ld_abort) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (ld_valid) begin
          // Address wraps naturally at DEPTH-1 -> 0 through the ADDR_W-bit add.
          waddr_d  = waddr_q + ADDR_W'(1);
          remain_d = remain_q - CNT_W'(1);
          csum_d   = csum_q + ld_data;
          if (remain_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Status outputs are decoded from the next state so they come straight out of flops.
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d == S_LOAD);
    hold_d  = (state_d == S_LOAD);
    done_d  = (state_d == S_DONE);
  end

  // Control and status registers; reset kills any burst silently (no done pulse).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      waddr_q   <= '0;
      remain_q  <= '0;
      csum_q    <= '0;
      aborted_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hold_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      waddr_q   <= waddr_d;
      remain_q  <= remain_d;
      csum_q    <= csum_d;
      aborted_q <= aborted_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hold_q    <= hold_d;
    end
  end

  // Memory write port; reads below see the old word until after this edge.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[waddr_q] <= ld_data;
    end
  end

  assign dbg_data   = mem[dbg_addr];
  assign rd_data    = hold_q ? '0 : mem[rd_addr];
  assign host_hold  = hold_q;
  assign ld_ready   = ready_q;
  assign ld_busy    = busy_q;
  assign ld_done    = done_q;
  assign ld_aborted = aborted_q;
  assign ld_csum    = csum_q;

endmodule
